// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - decoded digit record stream between decoder and consumer
interface seg7_scan_decoder_if #(
    parameter int DIG_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [DIG_W-1:0] out_digit;
    logic [3:0]       out_data;
    logic             out_mode;
    logic             out_err;

    modport master (
        output out_valid,
        output out_digit,
        output out_data,
        output out_mode,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_data,
        input  out_mode,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment bus decoder, optional SEG7_SYNC_EN input synchronizer
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIG_W         = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] an,
    input  logic [6:0]            seg,
    input  logic                  dp,
    seg7_scan_decoder_if.master   out,
    output logic                  overrun
);
    localparam int SW    = NUM_DIGITS + 8;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Record layout: {data[3:0], mode, err}
    function automatic logic [5:0] decode(input logic [6:0] g, input logic d);
        logic [5:0] r;
        r = 6'b0000_01;
        if (d) begin
            case (g)
                7'h01: r = {4'h0, 2'b00};
                7'h4F: r = {4'h1, 2'b00};
                7'h12: r = {4'h2, 2'b00};
                7'h06: r = {4'h3, 2'b00};
                7'h4C: r = {4'h4, 2'b00};
                7'h24: r = {4'h5, 2'b00};
                7'h20: r = {4'h6, 2'b00};
                7'h0F: r = {4'h7, 2'b00};
                7'h00: r = {4'h8, 2'b00};
                7'h0C: r = {4'h9, 2'b00};
                7'h08: r = {4'hA, 2'b00};
                7'h60: r = {4'hB, 2'b00};
                7'h31: r = {4'hC, 2'b00};
                7'h42: r = {4'hD, 2'b00};
                7'h30: r = {4'hE, 2'b00};
                7'h38: r = {4'hF, 2'b00};
                default: r = 6'b0000_01;
            endcase
        end else begin
            // Lit dp shows the magnitude glyph k of the negative value 16-k
            case (g)
                7'h4F: r = {4'hF, 2'b10};
                7'h12: r = {4'hE, 2'b10};
                7'h06: r = {4'hD, 2'b10};
                7'h4C: r = {4'hC, 2'b10};
                7'h24: r = {4'hB, 2'b10};
                7'h20: r = {4'hA, 2'b10};
                7'h0F: r = {4'h9, 2'b10};
                7'h00: r = {4'h8, 2'b10};
                default: r = 6'b0000_01;
            endcase
        end
        return r;
    endfunction

    logic [SW-1:0] in_bus;

`ifdef SEG7_SYNC_EN
    logic [SW-1:0] sync1_q;
    logic [SW-1:0] sync2_q;

    // Two-flop synchronizer; resets to dark so nothing looks lit after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {an, seg, dp};
            sync2_q <= sync1_q;
        end
    end

    assign in_bus = sync2_q;
`else
    assign in_bus = {an, seg, dp};
`endif

    logic [NUM_DIGITS-1:0] in_an;
    logic [6:0]            in_seg;
    logic                  in_dp;

    assign in_an  = in_bus[SW-1 -: NUM_DIGITS];
    assign in_seg = in_bus[7:1];
    assign in_dp  = in_bus[0];

    logic             one_low;
    logic [DIG_W-1:0] in_idx;

    // Exactly one active anode selects a digit; anything else is blanking
    always_comb begin
        int zeros;
        zeros  = 0;
        in_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!in_an[i]) begin
                zeros  = zeros + 1;
                in_idx = DIG_W'(i);
            end
        end
        one_low = (zeros == 1);
    end

    logic [SW-1:0]    s_q;
    logic [CNT_W-1:0] cnt_q;
    logic             acc_q;
    logic [DIG_W-1:0] acc_digit_q;
    logic [5:0]       acc_rec_q;

    // Sample and stability counter; count saturates so a held digit is accepted once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            acc_digit_q <= '0;
            acc_rec_q   <= '0;
        end else begin
            s_q         <= in_bus;
            acc_digit_q <= in_idx;
            acc_rec_q   <= decode(in_seg, in_dp);
            if (one_low && (in_bus == s_q)) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                acc_q <= (cnt_q == CNT_LAST);
            end else begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end
        end
    end

    // Per-digit last emitted record, bit 6 marks the entry as filled
    logic [6:0] tbl_q [NUM_DIGITS];
    logic       emit_need;
    logic       can_load;

    assign emit_need = acc_q && ({1'b1, acc_rec_q} != tbl_q[acc_digit_q]);
    assign can_load  = !out.out_valid || out.out_ready;

    // Output register, change filter table and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out.out_valid <= 1'b0;
            out.out_digit <= '0;
            out.out_data  <= '0;
            out.out_mode  <= 1'b0;
            out.out_err   <= 1'b0;
            overrun       <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            overrun <= emit_need && !can_load;
            if (emit_need && can_load) begin
                out.out_valid        <= 1'b1;
                out.out_digit        <= acc_digit_q;
                out.out_data         <= acc_rec_q[5:2];
                out.out_mode         <= acc_rec_q[1];
                out.out_err          <= acc_rec_q[0];
                tbl_q[acc_digit_q]   <= {1'b1, acc_rec_q};
            end else if (out.out_valid && out.out_ready) begin
                out.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;
    localparam int STABLE = 8;
`ifdef SEG7_SYNC_EN
    localparam int LAT = STABLE + 4;
`else
    localparam int LAT = STABLE + 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       overrun;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int ovr_cnt  = 0;
    logic [7:0] rec_q[$];

    seg7_scan_decoder_if #(.DIG_W(2)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS(4),
        .DIG_W(2),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .an(an),
        .seg(seg),
        .dp(dp),
        .out(bus.master),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Collect transferred records {digit, data, mode, err} and overrun pulses
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready)
            rec_q.push_back({bus.out_digit, bus.out_data, bus.out_mode, bus.out_err});
        if (rst_n && overrun)
            ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input logic [1:0] d, input logic [3:0] v,
                             input logic m, input logic e);
        logic [7:0] r;
        chk({tag, "_present"}, 32'(rec_q.size() > 0), 32'd1);
        if (rec_q.size() > 0) begin
            r = rec_q.pop_front();
            chk({tag, "_rec"}, {24'd0, r}, {24'd0, d, v, m, e});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d);
        an  = a;
        seg = s;
        dp  = d;
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    initial begin
        logic [6:0] glyph [4];
        logic [3:0] value [4];
        int ovr_base;

        glyph[0] = 7'h01; value[0] = 4'h0;
        glyph[1] = 7'h24; value[1] = 4'h5;
        glyph[2] = 7'h08; value[2] = 4'hA;
        glyph[3] = 7'h38; value[3] = 4'hF;

        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        show(4'hF, 7'h7F, 1'b1);
        cyc(2);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_fields", {26'd0, bus.out_digit, bus.out_data},  32'd0);
        chk("reset_flags", {29'd0, bus.out_mode, bus.out_err, overrun}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Digit 0 shows 3 for 20 cycles
        show(4'b1110, 7'h06, 1'b1);
        cyc(LAT - 1);
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        cyc(1);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_fields", {24'd0, bus.out_digit, bus.out_data, bus.out_mode, bus.out_err},
            {24'd0, 2'd0, 4'h3, 1'b0, 1'b0});
        cyc(20 - LAT);
        chk("no_repeat", 32'(rec_q.size()), 32'd1);
        check_rec("d0_three", 2'd0, 4'h3, 1'b0, 1'b0);

        // Digit 2 negative form, then an illegal lit-dp pattern
        show(4'b1011, 7'h12, 1'b0);
        cyc(LAT);
        chk("neg_valid", 32'(bus.out_valid), 32'd1);
        cyc(6);
        check_rec("d2_negE", 2'd2, 4'hE, 1'b1, 1'b0);
        show(4'b1011, 7'h01, 1'b0);
        cyc(LAT + 6);
        chk("err_count", 32'(rec_q.size()), 32'd1);
        if (rec_q.size() > 0) begin
            logic [7:0] r;
            r = rec_q.pop_front();
            chk("err_flag", 32'(r[0]), 32'd1);
            chk("err_data", 32'(r[5:2]), 32'd0);
            chk("err_digit", 32'(r[7:6]), 32'd2);
        end

        // Two scan passes over 0,5,A,F: second pass filtered
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                show(an_of(d), glyph[d], 1'b1);
                cyc(16);
            end
        end
        chk("scan_count", 32'(rec_q.size()), 32'd4);
        for (int d = 0; d < 4; d++)
            check_rec("scan", 2'(d), value[d], 1'b0, 1'b0);

        // Overrun: consumer stalls while a second digit is accepted
        ovr_base = ovr_cnt;
        bus.out_ready = 1'b0;
        show(an_of(0), 7'h00, 1'b1);
        cyc(16);
        show(an_of(1), 7'h4F, 1'b1);
        cyc(16);
        chk("ovr_pulse", 32'(ovr_cnt - ovr_base), 32'd1);
        chk("ovr_held", {24'd0, bus.out_valid, bus.out_digit, bus.out_data, bus.out_err},
            {24'd0, 1'b1, 2'd0, 4'h8, 1'b0});
        bus.out_ready = 1'b1;
        cyc(4);
        show(an_of(0), 7'h00, 1'b1);
        cyc(16);
        show(an_of(1), 7'h4F, 1'b1);
        cyc(16);
        chk("ovr_recs", 32'(rec_q.size()), 32'd2);
        check_rec("ovr_first", 2'd0, 4'h8, 1'b0, 1'b0);
        check_rec("ovr_reemit", 2'd1, 4'h1, 1'b0, 1'b0);
        chk("ovr_total", 32'(ovr_cnt - ovr_base), 32'd1);

        // Glitching segments never settle; two anodes low is blanking
        for (int i = 0; i < 8; i++) begin
            show(an_of(3), (i % 2 == 1) ? 7'h30 : 7'h38, 1'b1);
            cyc(5);
        end
        chk("glitch_none", 32'(rec_q.size()), 32'd0);
        show(4'b1100, 7'h06, 1'b1);
        cyc(30);
        chk("blank_none", 32'(rec_q.size()), 32'd0);
        chk("blank_quiet", {30'd0, bus.out_valid, bus.out_err}, 32'd0);

        // Reset mid-count discards the partial count
        show(an_of(1), 7'h06, 1'b1);
        cyc(5);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_out", {29'd0, bus.out_valid, bus.out_err, overrun}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(LAT - 1);
        chk("rst_mid_early", 32'(bus.out_valid), 32'd0);
        cyc(1);
        chk("rst_mid_emit", {26'd0, bus.out_digit, bus.out_data}, {26'd0, 2'd1, 4'h3});
        cyc(4);
        check_rec("rst_mid_rec", 2'd1, 4'h3, 1'b0, 1'b0);

        // Reset while a record is held; same digit re-emits afterwards
        bus.out_ready = 1'b0;
        show(an_of(1), 7'h0C, 1'b1);
        cyc(LAT);
        chk("hold_valid", {26'd0, bus.out_valid, bus.out_digit, bus.out_data[2:0]},
            {26'd0, 1'b1, 2'd1, 3'h1});
        #1 rst_n = 1'b0;
        #1 chk("rst_hold_out",
               {24'd0, bus.out_valid, bus.out_digit, bus.out_data, bus.out_mode},
               32'd0);
        chk("rst_hold_flags", {30'd0, bus.out_err, overrun}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(LAT - 1);
        chk("reemit_early", 32'(bus.out_valid), 32'd0);
        cyc(1);
        chk("reemit_fields", {25'd0, bus.out_valid, bus.out_digit, bus.out_data},
            {25'd0, 1'b1, 2'd1, 4'h9});
        bus.out_ready = 1'b1;
        cyc(3);
        chk("reemit_count", 32'(rec_q.size()), 32'd1);
        check_rec("reemit_rec", 2'd1, 4'h9, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
